lsu_mem_ctrl: RTL and testbench

Load/store controller sitting between the RV32IM memory stage and the word-wide data RAM. It accepts one load or store request at a time, drives the RAM's word-aligned port (`we`, `addr`, `din`, `dout`), and returns sign- or zero-extended load data. Byte and halfword stores are performed as read-modify-write, because the RAM has no byte enables. Memory-stage control must stall until `resp_valid`.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_mem_ctrl_align.sv | 93 +++++++++
 rtl/lsu_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
// Holds RISC-V funct3 width codes, the FSM state encoding, byte/halfword
// lane selectors, the captured-request payload and a word-address helper.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    // RISC-V load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Byte lane within a word, selected by addr[1:0]
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    // Halfword lane within a word, selected by addr[1]
    localparam logic LANE_H_LO = 1'b0;
    localparam logic LANE_H_HI = 1'b1;

    // Request fields kept for the duration of one access
    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [1:0]      lane;
        logic [XLEN-1:0] wdata;
    } req_t;

    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic for the load/store controller.
// Ports:
//   word       - current RAM word
//   wdata      - right-aligned store data
//   addr_lo    - byte offset addr[1:0]
//   funct3     - RISC-V width/sign code
//   we         - 1 = store, 0 = load
//   load_data  - extracted and sign/zero-extended load value
//   store_word - word with the store lane replaced (raw wdata for SW)
//   err        - illegal funct3, or misaligned when LSU_MISALIGN_CHECK_EN
// Build option: `define LSU_MISALIGN_CHECK_EN enables misalignment errors.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic            we,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_word,
    output logic            err
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        illegal;
    logic        misalign;

    // Load lane extract and extend
    always_comb begin
        byte_v = word[7:0];
        case (addr_lo)
            LANE_B1: byte_v = word[15:8];
            LANE_B2: byte_v = word[23:16];
            LANE_B3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = (addr_lo[1] == LANE_H_HI) ? word[31:16] : word[15:0];

        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'd0, byte_v};
            F3_HU:   load_data = {16'd0, half_v};
            default: load_data = '0;
        endcase
    end

    // Store merge: overwrite only the addressed lane of the old word
    always_comb begin
        store_word = word;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    LANE_B1: store_word[15:8]  = wdata[7:0];
                    LANE_B2: store_word[23:16] = wdata[7:0];
                    LANE_B3: store_word[31:24] = wdata[7:0];
                    default: store_word[7:0]   = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (addr_lo[1] == LANE_H_LO) store_word[15:0]  = wdata[15:0];
                else                         store_word[31:16] = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

    // Error flag; unsigned widths exist only for loads
    always_comb begin
        illegal = 1'b1;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = we;
            default:          illegal = 1'b1;
        endcase

        misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        case (funct3)
            F3_H, F3_HU: misalign = addr_lo[0];
            F3_W:        misalign = |addr_lo;
            default:     misalign = 1'b0;
        endcase
`endif
        err = illegal | misalign;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the memory stage and a word-wide RAM.
// One request at a time; byte/halfword stores are read-modify-write.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   req_valid/req_ready     - request handshake (ready only when idle)
//   req_we, req_funct3      - store flag and RISC-V width code
//   req_addr, req_wdata     - byte address and right-aligned store data
//   resp_valid              - one-cycle completion pulse
//   resp_rdata, resp_err    - extended load data / error, held until next response
//   mem_we, mem_addr        - RAM write enable and word-aligned address
//   mem_wdata, mem_rdata    - RAM write word and combinational read word
// Build option: `define LSU_MISALIGN_CHECK_EN enables misalignment errors.
module lsu_mem_ctrl
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t          state;
    req_t            cur;
    logic            idle;
    logic [1:0]      al_addr;
    logic [2:0]      al_funct3;
    logic            al_we;
    logic [XLEN-1:0] al_load;
    logic [XLEN-1:0] al_store;
    logic            al_err;

    // Lane logic checks the incoming request while idle, the captured one otherwise
    assign idle      = (state == ST_IDLE);
    assign al_addr   = idle ? req_addr[1:0] : cur.lane;
    assign al_funct3 = idle ? req_funct3    : cur.funct3;
    assign al_we     = idle ? req_we        : cur.we;

    lsu_align u_align (
        .word       (mem_rdata),
        .wdata      (cur.wdata),
        .addr_lo    (al_addr),
        .funct3     (al_funct3),
        .we         (al_we),
        .load_data  (al_load),
        .store_word (al_store),
        .err        (al_err)
    );

    // Controller FSM; RAM-side outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        cur.we     <= req_we;
                        cur.funct3 <= req_funct3;
                        cur.lane   <= req_addr[1:0];
                        cur.wdata  <= req_wdata;
                        req_ready  <= 1'b0;
                        if (al_err) begin
                            // Rejected without touching the RAM
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_we) begin
                            state    <= ST_LOAD;
                            mem_addr <= word_addr(req_addr);
                        end else if (req_funct3 == F3_W) begin
                            state     <= ST_WRITE;
                            mem_addr  <= word_addr(req_addr);
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= ST_MERGE;
                            mem_addr <= word_addr(req_addr);
                        end
                    end
                end
                ST_LOAD: begin
                    state      <= ST_RESP;
                    mem_addr   <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= al_load;
                    resp_err   <= 1'b0;
                end
                ST_MERGE: begin
                    state     <= ST_WRITE;
                    mem_we    <= 1'b1;
                    mem_wdata <= al_store;
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    mem_we     <= 1'b0;
                    mem_wdata  <= '0;
                    mem_addr   <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural word RAM.
// Expectations follow the build option LSU_MISALIGN_CHECK_EN.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] ram [256];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = ram[mem_addr[9:2]];

    lsu_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        check({tag, "_rerr"}, 32'(resp_err), 32'd0);
        check({tag, "_mwe"}, 32'(mem_we), 32'd0);
        check({tag, "_maddr"}, mem_addr, 32'd0);
        check({tag, "_mwdata"}, mem_wdata, 32'd0);
    endtask

    // One request from idle; lat = edges after acceptance until resp_valid is seen
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_writes);
        int lat;
        int writes;
        logic [31:0] waddr;
        lat = 0;
        writes = 0;
        waddr = '0;
        check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (mem_we) begin
                writes++;
                waddr = mem_addr;
            end
            if (resp_valid) lat = c;
            else begin
                check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
                tick();
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_writes"}, 32'(writes), 32'(exp_writes));
        if (exp_writes > 0) check({tag, "_waddr"}, waddr, {addr[31:2], 2'b00});
        tick();
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // SW then LW round trip
        run_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
        check("ram_10", ram[4], 32'hDEADBEEF);
        run_req("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

        // SB read-modify-write
        run_req("sw_20", 1'b1, 3'b010, 32'h20, 32'h11223344, 2, 32'h0, 1'b0, 1);
        run_req("sb_22", 1'b1, 3'b000, 32'h22, 32'h000000AA, 3, 32'h0, 1'b0, 1);
        check("ram_20", ram[8], 32'h11AA3344);

        // Load extension variants
        run_req("sw_30", 1'b1, 3'b010, 32'h30, 32'h8000FF7F, 2, 32'h0, 1'b0, 1);
        run_req("lb_30",  1'b0, 3'b000, 32'h30, 32'h0, 2, 32'h0000007F, 1'b0, 0);
        run_req("lb_31",  1'b0, 3'b000, 32'h31, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 0);
        run_req("lbu_31", 1'b0, 3'b100, 32'h31, 32'h0, 2, 32'h000000FF, 1'b0, 0);
        run_req("lh_32",  1'b0, 3'b001, 32'h32, 32'h0, 2, 32'hFFFF8000, 1'b0, 0);
        run_req("lhu_32", 1'b0, 3'b101, 32'h32, 32'h0, 2, 32'h00008000, 1'b0, 0);

        // Misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
        run_req("lw_21", 1'b0, 3'b010, 32'h21, 32'h0, 1, 32'h0, 1'b1, 0);
        run_req("lh_33", 1'b0, 3'b001, 32'h33, 32'h0, 1, 32'h0, 1'b1, 0);
`else
        run_req("lw_21", 1'b0, 3'b010, 32'h21, 32'h0, 2, 32'h11AA3344, 1'b0, 0);
        run_req("lh_33", 1'b0, 3'b001, 32'h33, 32'h0, 2, 32'hFFFF8000, 1'b0, 0);
`endif

        // Illegal funct3 codes
        run_req("ld_f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 1, 32'h0, 1'b1, 0);
        run_req("st_f3_100", 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 0);
        check("ram_20_kept", ram[8], 32'h11AA3344);

        // req_valid held through an SH; the next request is taken only back in idle
        check("hold_ready0", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h32;
        req_wdata  = 32'h1234ABCD;
        tick();
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h30;
        req_wdata  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("hold_busy_ready", 32'(req_ready), 32'd0);
            check("hold_busy_rvalid", 32'(resp_valid), 32'(i == 2));
            check("hold_busy_mwe", 32'(mem_we), 32'(i == 1));
            tick();
        end
        check("hold_back_idle", 32'(req_ready), 32'd1);
        check("ram_30_sh", ram[12], 32'hABCDFF7F);
        tick();
        req_valid = 1'b0;
        check("hold_second_taken", 32'(req_ready), 32'd0);
        tick();
        check("hold_second_rvalid", 32'(resp_valid), 32'd1);
        check("hold_second_rdata", resp_rdata, 32'hABCDFF7F);
        tick();

        // Reset while in MERGE: no write, no response
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h30;
        req_wdata  = 32'h00000055;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_merge");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_merge_no_resp", 32'(resp_valid), 32'd0);
            check("rst_merge_no_we", 32'(mem_we), 32'd0);
            tick();
        end
        check("rst_merge_ram", ram[12], 32'hABCDFF7F);

        // Reset while in WRITE: RAM still commits, no response
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'hCAFEF00D;
        tick();
        req_valid = 1'b0;
        check("rst_write_mwe", 32'(mem_we), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_write_ram", ram[16], 32'hCAFEF00D);
        check_reset_outputs("rst_write");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_write_no_resp", 32'(resp_valid), 32'd0);
            tick();
        end

        // Reset together with a request in idle: request dropped
        run_req("sw_44", 1'b1, 3'b010, 32'h44, 32'h01010101, 2, 32'h0, 1'b0, 1);
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h44;
        req_wdata  = 32'hFFFFFFFF;
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        check("rst_idle_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst_idle_no_resp", 32'(resp_valid), 32'd0);
            check("rst_idle_no_we", 32'(mem_we), 32'd0);
            tick();
        end
        run_req("lw_44", 1'b0, 3'b010, 32'h44, 32'h0, 2, 32'h01010101, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
